// File: rtl/pim_outbuf_pkg.sv
// Shared types and helpers for the PIM output buffer: FSM states, default sizes
// and the bus-to-group slice mapping.
package pim_outbuf_pkg;

    localparam int unsigned NUM_GROUPS_DEF = 32;
    localparam int unsigned GROUP_W_DEF    = 32;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDone
    } state_e;

    // Group 0 sits in the MSB slice of the eFlash bus.
    function automatic int unsigned group_lsb(input int unsigned idx,
                                              input int unsigned num_groups,
                                              input int unsigned group_w);
        return (num_groups - 1 - idx) * group_w;
    endfunction

endpackage

// File: rtl/pim_outbuf_bank.sv
// Capture register bank: writes every group from the wide bus at once,
// reads one group selected by index.
module pim_outbuf_bank
    import pim_outbuf_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = NUM_GROUPS_DEF,
    parameter int unsigned GROUP_W    = GROUP_W_DEF
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            we_i,
    input  logic [NUM_GROUPS*GROUP_W-1:0]   data_i,
    input  logic [$clog2(NUM_GROUPS)-1:0]   rd_idx_i,
    output logic [GROUP_W-1:0]              rd_data_o
);

    logic [GROUP_W-1:0] bank_q [NUM_GROUPS];

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        localparam int unsigned Lsb = group_lsb(g, NUM_GROUPS, GROUP_W);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                bank_q[g] <= '0;
            end else if (we_i) begin
                bank_q[g] <= data_i[Lsb +: GROUP_W];
            end
        end
    end

    assign rd_data_o = bank_q[rd_idx_i];

endmodule

// File: rtl/pim_out_buffer_stream.sv
// PIM output buffer: captures a wide result word and streams a wrap-around
// range of groups over valid/ready with optional zero-point subtraction.
module pim_out_buffer_stream
    import pim_outbuf_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = NUM_GROUPS_DEF,
    parameter int unsigned GROUP_W    = GROUP_W_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_GROUPS*GROUP_W-1:0]       data_i,
    input  logic                                capture_i,
    input  logic                                zero_point_en_i,
    input  logic [GROUP_W-1:0]                  zero_point_i,
    input  logic                                load_start_i,
    input  logic [$clog2(NUM_GROUPS)-1:0]       load_base_i,
    input  logic [$clog2(NUM_GROUPS):0]         load_len_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [GROUP_W-1:0]                  out_data_o,
    output logic [$clog2(NUM_GROUPS)-1:0]       out_idx_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                err_o
);

    localparam int unsigned IDX_W = $clog2(NUM_GROUPS);
    localparam int unsigned LenMaxInt = NUM_GROUPS;
    localparam logic [IDX_W:0] LenMax = LenMaxInt[IDX_W:0];
    localparam logic [IDX_W:0] LenOne = {{IDX_W{1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [IDX_W:0]     remaining_q, remaining_d;
    logic [GROUP_W-1:0] zp_q, zp_d;
    logic               zp_en_q, zp_en_d;
    logic               err_q, err_d;
    logic               bank_we;
    logic [GROUP_W-1:0] rd_data;
    logic               len_ok;

    pim_outbuf_bank #(
        .NUM_GROUPS (NUM_GROUPS),
        .GROUP_W    (GROUP_W)
    ) u_bank (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (bank_we),
        .data_i    (data_i),
        .rd_idx_i  (cur_idx_q),
        .rd_data_o (rd_data)
    );

    assign len_ok = (load_len_i != '0) && (load_len_i <= LenMax);

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        remaining_d = remaining_q;
        zp_d        = zp_q;
        zp_en_d     = zp_en_q;
        err_d       = 1'b0;
        bank_we     = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_idx_o   = '0;

        unique case (state_q)
            StIdle, StDone: begin
                bank_we = capture_i;
                state_d = StIdle;
                if (load_start_i) begin
                    if (len_ok) begin
                        state_d     = StStream;
                        cur_idx_d   = load_base_i;
                        remaining_d = load_len_i;
                        zp_d        = zero_point_i;
                        zp_en_d     = zero_point_en_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StStream: begin
                out_valid_o = 1'b1;
                out_idx_o   = cur_idx_q;
                out_data_o  = rd_data - (zp_en_q ? zp_q : '0);
                // Bank is frozen and new bursts are refused while streaming.
                err_d       = capture_i | load_start_i;
                if (out_ready_i) begin
                    cur_idx_d   = cur_idx_q + IDX_W'(1);
                    remaining_d = remaining_q - LenOne;
                    if (remaining_q == LenOne) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cur_idx_q   <= '0;
            remaining_q <= '0;
            zp_q        <= '0;
            zp_en_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            remaining_q <= remaining_d;
            zp_q        <= zp_d;
            zp_en_q     <= zp_en_d;
            err_q       <= err_d;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);
    assign err_o  = err_q;

endmodule
